tile_blitter: RTL and testbench
===============================

TILE_BLITTER -- requirements
Module: tile_blitter

Interface
REQ-001 SHALL have parameter TILES_H, default 28, tile columns per row.
REQ-002 SHALL have parameter TILES_V, default 18, tile rows per frame.
REQ-003 SHALL have parameter VRAM_AW, default 7, VRAM byte-address width (ceil(TILES_H*TILES_V/4) = 126 bytes).
REQ-004 SHALL have port wclk, input, 1, clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port cmd_valid, input, 1, fill request present.
REQ-007 SHALL have port cmd_ready, output, 1, block idle and able to accept a command.
REQ-008 SHALL have port cmd_x, input, 5, left tile column.
REQ-009 SHALL have port cmd_y, input, 5, top tile row.
REQ-010 SHALL have port cmd_w, input, 5, width in tiles.
REQ-011 SHALL have port cmd_h, input, 5, height in tiles.
REQ-012 SHALL have port cmd_color, input, 2, palette index to write.
REQ-013 SHALL have port busy, output, 1, fill in progress.
REQ-014 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-015 SHALL have port err, output, 1, one-cycle rejection pulse.
REQ-016 SHALL have port vram_addr, output, VRAM_AW, byte address into the VRAM write port.
REQ-017 SHALL have port vram_wdata, output, 8, merged byte to write.
REQ-018 SHALL have port vram_wenable, output, 1, byte write strobe.
REQ-019 SHALL have port vram_rdata, input, 8, VRAM read data, valid the cycle after vram_addr is presented.

Function
REQ-020 SHALL accept a command on a wclk edge where cmd_valid and cmd_ready are both 1, and SHALL latch all cmd_* fields on that edge.
REQ-021 SHALL drive cmd_ready = 1 only in IDLE; cmd_* values at any other time SHALL be ignored.
REQ-022 SHALL implement FSM states IDLE, RD, WR, FIN: IDLE->RD on accept with a non-empty region; RD->WR always; WR->RD if tiles remain; WR->FIN after the last tile; FIN->IDLE always.
REQ-023 SHALL go IDLE->FIN directly on accept when cmd_w = 0, cmd_h = 0, or the region is empty after clipping; no VRAM writes occur.
REQ-024 SHALL visit tiles row-major from (x,y) and SHALL hold tile index idx = row*TILES_H + col in a 9-bit counter: +1 within a row, +(TILES_H - w + 1) at row end.
REQ-025 SHALL, in RD, drive vram_addr = idx[8:2] and vram_wenable = 0.
REQ-026 SHALL, in WR, hold the same vram_addr, drive vram_wenable = 1, and drive vram_wdata = vram_rdata with bits [2*idx[1:0]+1 : 2*idx[1:0]] replaced by the latched color.
REQ-027 SHALL pulse done = 1 for exactly the FIN cycle; busy SHALL be 1 exactly in RD and WR.
REQ-028 SHALL complete a w*h-tile fill with done asserted 1+2*w*h cycles after the accept edge.
REQ-029 SHALL drive vram_wenable = 0 in every state other than WR.

Reset
REQ-030 SHALL, on rst_n low, force IDLE with cmd_ready = 1, busy = 0, done = 0, err = 0, vram_wenable = 0, vram_addr = 0, vram_wdata = 0.
REQ-031 SHALL abandon a fill when reset asserts mid-operation; bytes already written stay in VRAM and no done pulse is produced.

Configuration
REQ-032 SHALL, with TILE_BLITTER_CLIP_EN defined, clip the region to w' = min(w, TILES_H - x), h' = min(h, TILES_V - y); x >= TILES_H or y >= TILES_V SHALL give an empty region (done, no writes, err = 0).
REQ-033 SHALL, without TILE_BLITTER_CLIP_EN, reject any command with x + w > TILES_H or y + h > TILES_V: no writes, and err and done both pulsed in the FIN cycle.

Structure
REQ-034 SHALL take TILES_H, TILES_V and the FSM state encoding from the shared video package also used by video_unit.
REQ-035 SHALL contain no sub-module; the byte merge is inline logic.

Verification
REQ-036 SHALL verify fill x=0,y=0,w=1,h=1,color=3 over VRAM byte0 = 0x00 -> one write, addr 0, wdata 0x03, done 3 cycles after accept.
REQ-037 SHALL verify fill x=2,y=0,w=4,h=1,color=1 over bytes 0xFF -> byte0 = 0x5F, byte1 = 0xF5, 4 writes, done at cycle 9.
REQ-038 SHALL verify fill x=27,y=17,w=1,h=1,color=2 -> idx 503, addr 125, bits [7:6] = 2'b10.
REQ-039 SHALL verify fill x=26,y=0,w=4,h=2 -> with TILE_BLITTER_CLIP_EN, 4 writes covering tiles 26,27,54,55; without it, err = 1, done = 1, no writes.
REQ-040 SHALL verify cmd_w = 0 -> done 1 cycle after accept, no writes, busy never set.
REQ-041 SHALL verify rst_n pulsed low during the third tile of a 3x3 fill -> outputs at reset values, tiles 1-2 written, no done pulse.

Source files
------------

// File: rtl/video_pkg.sv
// Shared video constants and the blitter FSM encoding, used by tile_blitter and video_unit.
package video_pkg;

  localparam int VID_TILES_H = 28;
  localparam int VID_TILES_V = 18;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_FIN  = 2'd3
  } blit_state_e;

endpackage

// File: rtl/tile_blitter.sv
// Rectangular tile fill into a 2-bit-per-tile VRAM via read-modify-write of packed bytes.
// Optional feature: define TILE_BLITTER_CLIP_EN to clip regions instead of rejecting them.
module tile_blitter
  import video_pkg::*;
#(
  parameter int TILES_H = VID_TILES_H,
  parameter int TILES_V = VID_TILES_V,
  parameter int VRAM_AW = 7
) (
  input  logic               wclk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [4:0]         cmd_x,
  input  logic [4:0]         cmd_y,
  input  logic [4:0]         cmd_w,
  input  logic [4:0]         cmd_h,
  input  logic [1:0]         cmd_color,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic [7:0]         vram_wdata,
  output logic               vram_wenable,
  input  logic [7:0]         vram_rdata
);

  localparam logic [5:0] TH6 = 6'(TILES_H);
  localparam logic [5:0] TV6 = 6'(TILES_V);

  blit_state_e state_q, state_d;
  logic [8:0]  idx_q, idx_d;
  logic [4:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic [4:0]  w_q, w_d;
  logic [1:0]  color_q, color_d;
  logic        err_flag_q, err_flag_d;

  logic [5:0]  x6_s, y6_s, w6_s, h6_s;
  logic [5:0]  w_eff_s, h_eff_s;
  logic        reject_s, empty_s;
  logic [10:0] idx_full_s;
  logic [7:0]  merged_s;

  assign x6_s       = {1'b0, cmd_x};
  assign y6_s       = {1'b0, cmd_y};
  assign w6_s       = {1'b0, cmd_w};
  assign h6_s       = {1'b0, cmd_h};
  assign idx_full_s = 11'(cmd_y) * 11'(TILES_H) + 11'(cmd_x);

`ifdef TILE_BLITTER_CLIP_EN
  // Clip the requested rectangle to the frame; an origin off-frame yields an empty region.
  always_comb begin
    reject_s = 1'b0;
    w_eff_s  = 6'd0;
    h_eff_s  = 6'd0;
    if ((x6_s >= TH6) || (y6_s >= TV6)) begin
      w_eff_s = 6'd0;
      h_eff_s = 6'd0;
    end else begin
      w_eff_s = (w6_s > (TH6 - x6_s)) ? (TH6 - x6_s) : w6_s;
      h_eff_s = (h6_s > (TV6 - y6_s)) ? (TV6 - y6_s) : h6_s;
    end
  end
`else
  // Any rectangle reaching past the frame edge is rejected outright.
  always_comb begin
    reject_s = ((x6_s + w6_s) > TH6) || ((y6_s + h6_s) > TV6);
    w_eff_s  = w6_s;
    h_eff_s  = h6_s;
  end
`endif

  assign empty_s = reject_s || (w_eff_s == 6'd0) || (h_eff_s == 6'd0);

  // Next-state and datapath update for the fill sequencer.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    col_d      = col_q;
    row_d      = row_q;
    w_d        = w_q;
    color_d    = color_q;
    err_flag_d = err_flag_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          color_d    = cmd_color;
          w_d        = w_eff_s[4:0];
          col_d      = w_eff_s[4:0] - 5'd1;
          row_d      = h_eff_s[4:0] - 5'd1;
          idx_d      = idx_full_s[8:0];
          err_flag_d = reject_s;
          state_d    = empty_s ? ST_FIN : ST_RD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD: state_d = ST_WR;
      ST_WR: begin
        if (col_q != 5'd0) begin
          idx_d   = idx_q + 9'd1;
          col_d   = col_q - 5'd1;
          state_d = ST_RD;
        end else if (row_q != 5'd0) begin
          // Jump from the last tile of this row to the first tile of the next.
          idx_d   = idx_q + 9'(TILES_H) - {4'd0, w_q} + 9'd1;
          col_d   = w_q - 5'd1;
          row_d   = row_q - 5'd1;
          state_d = ST_RD;
        end else begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        err_flag_d = 1'b0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer registers with asynchronous reset.
  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= 9'd0;
      col_q      <= 5'd0;
      row_q      <= 5'd0;
      w_q        <= 5'd0;
      color_q    <= 2'd0;
      err_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      col_q      <= col_d;
      row_q      <= row_d;
      w_q        <= w_d;
      color_q    <= color_d;
      err_flag_q <= err_flag_d;
    end
  end

  // Replace the 2-bit slot of the current tile inside the byte read back in RD.
  always_comb begin
    merged_s = vram_rdata;
    case (idx_q[1:0])
      2'd0:    merged_s[1:0] = color_q;
      2'd1:    merged_s[3:2] = color_q;
      2'd2:    merged_s[5:4] = color_q;
      2'd3:    merged_s[7:6] = color_q;
      default: merged_s      = vram_rdata;
    endcase
  end

  assign cmd_ready    = (state_q == ST_IDLE);
  assign busy         = (state_q == ST_RD) || (state_q == ST_WR);
  assign done         = (state_q == ST_FIN);
  assign err          = (state_q == ST_FIN) && err_flag_q;
  assign vram_wenable = (state_q == ST_WR);
  assign vram_addr    = busy ? VRAM_AW'(idx_q[8:2]) : '0;
  assign vram_wdata   = (state_q == ST_WR) ? merged_s : 8'd0;

endmodule

// File: tb/tb_tile_blitter.sv
// Scoreboarded bench for tile_blitter against a behavioural byte-wide VRAM.
module tb_tile_blitter;

  logic       wclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [4:0] cmd_x = 5'd0, cmd_y = 5'd0, cmd_w = 5'd0, cmd_h = 5'd0;
  logic [1:0] cmd_color = 2'd0;
  logic       busy, done, err;
  logic [6:0] vram_addr;
  logic [7:0] vram_wdata;
  logic       vram_wenable;
  logic [7:0] vram_rdata = 8'd0;

  logic [7:0] vram    [0:127];
  logic [7:0] ref_mem [0:127];
  logic       preset_en = 1'b0;
  logic [7:0] preset_val = 8'd0;

  typedef struct {
    logic [6:0] a;
    logic [7:0] d;
  } wr_t;
  wr_t exp_q[$];

  int total = 0;
  int bad = 0;
  int done_cyc, n_wr;
  bit err_seen, busy_seen;

  tile_blitter dut (
    .wclk(wclk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
    .busy(busy), .done(done), .err(err), .vram_addr(vram_addr), .vram_wdata(vram_wdata),
    .vram_wenable(vram_wenable), .vram_rdata(vram_rdata)
  );

  always #5 wclk = ~wclk;

  // Synchronous-read VRAM model with a bulk preset port.
  always @(posedge wclk) begin
    vram_rdata <= vram[vram_addr];
    if (preset_en) begin
      for (int i = 0; i < 128; i++) vram[i] <= preset_val;
    end else if (vram_wenable) begin
      vram[vram_addr] <= vram_wdata;
    end
  end

  task automatic preset(input logic [7:0] v);
    @(negedge wclk);
    preset_val = v;
    preset_en  = 1'b1;
    @(negedge wclk);
    preset_en  = 1'b0;
    for (int i = 0; i < 128; i++) ref_mem[i] = v;
  endtask

  // Reference model: derive every expected write from the command.
  task automatic push_expected(input int x, input int y, input int w, input int h, input int c);
    int we, he, t;
    logic [7:0] b;
    we = w;
    he = h;
`ifdef TILE_BLITTER_CLIP_EN
    if (x >= 28 || y >= 18) begin
      we = 0;
    end else begin
      if (we > 28 - x) we = 28 - x;
      if (he > 18 - y) he = 18 - y;
    end
`else
    if (x + w > 28 || y + h > 18) we = 0;
`endif
    for (int r = 0; r < he; r++) begin
      for (int k = 0; k < we; k++) begin
        t = (y + r) * 28 + x + k;
        b = ref_mem[t / 4];
        b[2 * (t % 4) +: 2] = 2'(c);
        ref_mem[t / 4] = b;
        exp_q.push_back('{a: 7'(t / 4), d: b});
      end
    end
  endtask

  task automatic drive_cmd(input int x, input int y, input int w, input int h, input int c);
    push_expected(x, y, w, h, c);
    @(negedge wclk);
    cmd_x = 5'(x); cmd_y = 5'(y); cmd_w = 5'(w); cmd_h = 5'(h); cmd_color = 2'(c);
    cmd_valid = 1'b1;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL accept_ready got=%b want=1", cmd_ready);
    end
    @(posedge wclk);
    #1;
    // Garbage on the command bus while busy must be ignored.
    cmd_x = 5'd31; cmd_y = 5'd31; cmd_w = 5'd7; cmd_h = 5'd7; cmd_color = 2'd0;
  endtask

  task automatic collect(input int budget);
    wr_t e;
    done_cyc = -1; n_wr = 0; err_seen = 1'b0; busy_seen = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge wclk);
      if (c == 1) cmd_valid = 1'b0;
      if (busy) busy_seen = 1'b1;
      if (vram_wenable) begin
        n_wr++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_extra_write got addr=%0d data=%h want=none", vram_addr, vram_wdata);
        end else begin
          e = exp_q.pop_front();
          if (vram_addr !== e.a || vram_wdata !== e.d) begin
            bad++;
            $display("FAIL sb_write got addr=%0d data=%h want addr=%0d data=%h",
                     vram_addr, vram_wdata, e.a, e.d);
          end
        end
      end
      if (done) begin
        done_cyc = c;
        err_seen = err;
        break;
      end
    end
    total++;
    if (done_cyc < 0) begin
      bad++;
      $display("FAIL done_timeout got=none want=done within %0d", budget);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_missing got=%0d pending want=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    @(negedge wclk);
    @(negedge wclk);
    total++;
    if ({cmd_ready, busy, done, err, vram_wenable} !== 5'b10000) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=10000", {cmd_ready, busy, done, err, vram_wenable});
    end
    total++;
    if (vram_addr !== 7'd0 || vram_wdata !== 8'd0) begin
      bad++;
      $display("FAIL reset_bus got addr=%0d data=%h want 0/00", vram_addr, vram_wdata);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    preset(8'h00);
    drive_cmd(0, 0, 1, 1, 3);
    collect(20);
    total++;
    if (done_cyc != 3 || n_wr != 1 || err_seen !== 1'b0) begin
      bad++;
      $display("FAIL single got cyc=%0d wr=%0d err=%b want 3/1/0", done_cyc, n_wr, err_seen);
    end
    @(negedge wclk);
    total++;
    if (vram[0] !== 8'h03) begin
      bad++;
      $display("FAIL single_byte got=%h want=03", vram[0]);
    end
  endtask

  task automatic test_row;
    preset(8'hFF);
    drive_cmd(2, 0, 4, 1, 1);
    collect(30);
    total++;
    if (done_cyc != 9 || n_wr != 4) begin
      bad++;
      $display("FAIL row got cyc=%0d wr=%0d want 9/4", done_cyc, n_wr);
    end
    @(negedge wclk);
    total++;
    if (vram[0] !== 8'h5F || vram[1] !== 8'hF5) begin
      bad++;
      $display("FAIL row_bytes got=%h %h want=5f f5", vram[0], vram[1]);
    end
  endtask

  task automatic test_corner;
    preset(8'h00);
    drive_cmd(27, 17, 1, 1, 2);
    collect(20);
    @(negedge wclk);
    total++;
    if (done_cyc != 3 || vram[125] !== 8'h80) begin
      bad++;
      $display("FAIL corner got cyc=%0d byte125=%h want 3/80", done_cyc, vram[125]);
    end
  endtask

  task automatic test_clip;
    preset(8'h00);
    drive_cmd(26, 0, 4, 2, 3);
    collect(30);
    @(negedge wclk);
`ifdef TILE_BLITTER_CLIP_EN
    total++;
    if (done_cyc != 9 || n_wr != 4 || err_seen !== 1'b0) begin
      bad++;
      $display("FAIL clip got cyc=%0d wr=%0d err=%b want 9/4/0", done_cyc, n_wr, err_seen);
    end
    total++;
    if (vram[6] !== 8'hF0 || vram[13] !== 8'hF0 || vram[7] !== 8'h00) begin
      bad++;
      $display("FAIL clip_bytes got=%h %h %h want=f0 f0 00", vram[6], vram[13], vram[7]);
    end
`else
    total++;
    if (done_cyc != 1 || n_wr != 0 || err_seen !== 1'b1 || busy_seen) begin
      bad++;
      $display("FAIL reject got cyc=%0d wr=%0d err=%b busy=%b want 1/0/1/0",
               done_cyc, n_wr, err_seen, busy_seen);
    end
    total++;
    if (vram[6] !== 8'h00) begin
      bad++;
      $display("FAIL reject_byte got=%h want=00", vram[6]);
    end
`endif
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL err_width got=%b want=0", err);
    end
  endtask

  task automatic test_zero_w;
    drive_cmd(0, 0, 0, 3, 2);
    collect(10);
    total++;
    if (done_cyc != 1 || n_wr != 0 || busy_seen || err_seen !== 1'b0) begin
      bad++;
      $display("FAIL zero_w got cyc=%0d wr=%0d busy=%b err=%b want 1/0/0/0",
               done_cyc, n_wr, busy_seen, err_seen);
    end
  endtask

  task automatic test_back_to_back;
    int x, y, w, h, c;
    preset(8'hA5);
    for (int i = 0; i < 4; i++) begin
      w = $urandom_range(1, 4); h = $urandom_range(1, 3);
      x = $urandom_range(0, 28 - w); y = $urandom_range(0, 18 - h);
      c = $urandom_range(0, 3);
      drive_cmd(x, y, w, h, c);
      collect(60);
      total++;
      if (done_cyc != 1 + 2 * w * h || n_wr != w * h) begin
        bad++;
        $display("FAIL b2b_%0d got cyc=%0d wr=%0d want %0d/%0d", i, done_cyc, n_wr,
                 1 + 2 * w * h, w * h);
      end
    end
  endtask

  task automatic test_reset_mid;
    int wr_cnt;
    bit late;
    preset(8'h00);
    exp_q.delete();
    wr_cnt = 0;
    late = 1'b0;
    @(negedge wclk);
    cmd_x = 5'd0; cmd_y = 5'd1; cmd_w = 5'd3; cmd_h = 5'd3; cmd_color = 2'd2;
    cmd_valid = 1'b1;
    @(posedge wclk);
    #1 cmd_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge wclk);
      if (vram_wenable) wr_cnt++;
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({cmd_ready, busy, done, err, vram_wenable} !== 5'b10000 ||
        vram_addr !== 7'd0 || vram_wdata !== 8'd0) begin
      bad++;
      $display("FAIL mid_reset_outs got=%b addr=%0d data=%h want=10000 0 00",
               {cmd_ready, busy, done, err, vram_wenable}, vram_addr, vram_wdata);
    end
    @(negedge wclk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge wclk);
      if (done || vram_wenable) late = 1'b1;
    end
    total++;
    if (wr_cnt != 2 || late || vram[7] !== 8'h0A) begin
      bad++;
      $display("FAIL mid_reset got wr=%0d late=%b byte7=%h want 2/0/0a", wr_cnt, late, vram[7]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_row();
    test_corner();
    test_clip();
    test_zero_w();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
